stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Downstream consumer of the stream-config select stream (`out_select`).
- Takes one select per packet over a ready/valid handshake, then routes one data packet from a single input stream to one of NUM_OUTPUTS output streams.
- Switches outputs only at packet boundaries (`in_last`) and drops packets whose select is out of range.
- Outputs are registered: one pipeline stage, full throughput.

Parameters:
- SELECT_WIDTH, 2, width of the select value.
- NUM_OUTPUTS, 4, number of output streams; must be between 1 and 2**SELECT_WIDTH inclusive.
- DATA_WIDTH, 64, width of one data beat.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sel_valid  in  1  select stream valid.
- sel_ready  out  1  select stream ready.
- sel_data  in  SELECT_WIDTH  output index for the next packet.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat ready.
- in_data  in  DATA_WIDTH  input beat payload.
- in_last  in  1  final beat of the packet.
- out_valid  out  NUM_OUTPUTS  per-output valid.
- out_ready  in  NUM_OUTPUTS  per-output ready.
- out_data  out  NUM_OUTPUTS*DATA_WIDTH  per-output payload; slice i belongs to output i.
- out_last  out  NUM_OUTPUTS  per-output last.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; all out_valid=0, out_last=0, out_data=0.
  - sel_ready=0 during the reset cycle; in_ready=0.
  - Any in-flight output beat is discarded; a packet interrupted mid-stream is not resumed.
- Handshakes:
  - A transfer occurs when valid&&ready are both high at the clock edge.
  - Valid must not depend on ready; the block never drops an offered out_valid before out_ready.
- FSM states:
  - IDLE:
    - sel_ready=1, in_ready=0.
    - On a sel transfer, latch sel_q=sel_data.
    - If sel_data<NUM_OUTPUTS go to ROUTE, else go to DROP.
  - ROUTE:
    - sel_ready=0.
    - in_ready = !out_valid[sel_q] || out_ready[sel_q].
    - On an in transfer, load output register sel_q with in_data/in_last and set out_valid[sel_q]=1.
    - If the accepted beat has in_last=1, go to IDLE.
  - DROP:
    - sel_ready=0, in_ready=1; beats are consumed and discarded, outputs untouched.
    - On an accepted beat with in_last=1, go to IDLE.
- Output register i:
  - Holds its beat until out_ready[i].
  - Clears out_valid[i] on out_ready[i] unless reloaded in the same cycle; reload and drain in one cycle is allowed, giving back-to-back beats at 1 beat/cycle.
- Latency:
  - Select to first in_ready: 1 cycle (the IDLE cycle).
  - Input beat to out_valid: 1 cycle.
  - There is a 1-cycle bubble between packets (the IDLE state); accepted.
- Single-beat packet (in_valid & in_last on the first ROUTE cycle): routed normally, return to IDLE next cycle.
- Packet boundary while the previous output still holds data:
  - In IDLE, a new select to a different output is accepted; the old output's pending beat drains independently.
  - A new select to the same output waits on that output's register via the in_ready rule.
- Select equal to NUM_OUTPUTS or greater: DROP, as above.
- Only one out_valid can be loaded per cycle; multiple out_valid may be high concurrently while draining.

Optional Feature:
- Macro: STREAM_DEMUX_STATS_EN.
- When defined:
  - Adds output ports pkt_count (NUM_OUTPUTS*32) and drop_count (32).
  - pkt_count[i] increments on each out_valid[i]&&out_ready[i]&&out_last[i].
  - drop_count increments on each IDLE→DROP transition.
  - All counters wrap modulo 2**32 and reset to 0.
- When undefined: no counter ports or logic; functional behaviour is otherwise identical.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, release.
  - Required: sel_ready=1 on the first post-reset cycle; in_ready=0; out_valid=0000.
- Basic route:
  - Select 2, 3-beat packet 0xA,0xB,0xC (last on 0xC), all out_ready=1.
  - Required: out_valid[2] high for 3 consecutive cycles, each one cycle after its input beat, with out_last only on 0xC; other outputs silent; sel_ready=1 the cycle after 0xC is accepted.
- Backpressure:
  - Select 1, out_ready[1]=0 for 4 cycles, then 1; offer 2 beats.
  - Required: first beat held in out_data slice 1; in_ready=0 while stalled; no beat lost or duplicated; order preserved.
- Out-of-range select:
  - NUM_OUTPUTS=3, select 3, 2-beat packet.
  - Required: in_ready=1 both beats; out_valid stays 000; IDLE afterwards; drop_count=1 with STATS_EN.
- Back-to-back packets:
  - Select 0 (1 beat, last), then select 1 (1 beat); out_ready[0]=0.
  - Required: output 0 keeps its beat while output 1 receives and delivers its beat; pkt_count = {0:1 after release, 1:1}.
- Reset mid-packet:
  - Assert rst after beat 1 of 3 to output 0.
  - Required: next cycle out_valid=000 and state IDLE; remaining beats only accepted after a new select.

Source files
------------

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - select-driven packet demux, one input to NUM_OUTPUTS registered outputs (optional counters: STREAM_DEMUX_STATS_EN)
module stream_demux #(
  parameter int SELECT_WIDTH = 2,
  parameter int NUM_OUTPUTS  = 4,
  parameter int DATA_WIDTH   = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sel_valid,
  output logic                              sel_ready,
  input  logic [SELECT_WIDTH-1:0]           sel_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  output logic [NUM_OUTPUTS-1:0]            out_valid,
  input  logic [NUM_OUTPUTS-1:0]            out_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUTPUTS-1:0]            out_last
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [NUM_OUTPUTS*32-1:0]         pkt_count,
  output logic [31:0]                       drop_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [SELECT_WIDTH-1:0] sel_q;
  logic                    sel_in_range;
  logic [NUM_OUTPUTS-1:0]  route_hit;
  logic [NUM_OUTPUTS-1:0]  slot_free;
  logic [NUM_OUTPUTS-1:0]  load_vec;
  logic [DATA_WIDTH-1:0]   data_q [NUM_OUTPUTS];

  // Compare one bit wider so NUM_OUTPUTS == 2**SELECT_WIDTH is representable.
  assign sel_in_range = {1'b0, sel_data} < (SELECT_WIDTH+1)'(NUM_OUTPUTS);

  // Decode the latched select and find which output registers can take a beat this cycle.
  always_comb begin
    route_hit = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      route_hit[i] = (sel_q == SELECT_WIDTH'(i));
    end
    slot_free = ~out_valid | out_ready;
  end

  // Next-state and handshake readies; both readies are forced low while reset is held.
  always_comb begin
    state_d   = state_q;
    sel_ready = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_ready = 1'b1;
        if (sel_valid) begin
          state_d = sel_in_range ? ROUTE : DROP;
        end
      end
      ROUTE: begin
        in_ready = |(route_hit & slot_free);
        if (in_valid && in_ready && in_last) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      sel_ready = 1'b0;
      in_ready  = 1'b0;
    end
  end

  // Only the selected output register loads, and only on an accepted beat while routing.
  assign load_vec = route_hit & {NUM_OUTPUTS{in_valid && in_ready && (state_q == ROUTE)}};

  // State register and select latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (sel_valid && sel_ready) begin
        sel_q <= sel_data;
      end
    end
  end

  // Output registers: a reload wins over a drain so a full slot can stream at one beat per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_last  <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (load_vec[i]) begin
          out_valid[i] <= 1'b1;
          out_last[i]  <= in_last;
          data_q[i]    <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_out_data
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
  end

`ifdef STREAM_DEMUX_STATS_EN
  logic [31:0] pkt_cnt_q [NUM_OUTPUTS];

  // Count completed packets per output and packets discarded for an out-of-range select.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && sel_valid && !sel_in_range) begin
        drop_count <= drop_count + 32'd1;
      end
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (out_valid[i] && out_ready[i] && out_last[i]) begin
          pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_pkt_count
    assign pkt_count[g*32 +: 32] = pkt_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed and randomized checks of stream_demux against a per-output packet scoreboard
module tb_stream_demux;
  localparam int SW = 2;
  localparam int N  = 3;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            sel_valid;
  logic            sel_ready;
  logic [SW-1:0]   sel_data;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_last;
`ifdef STREAM_DEMUX_STATS_EN
  logic [N*32-1:0] pkt_count;
  logic [31:0]     drop_count;
`endif

  stream_demux #(.SELECT_WIDTH(SW), .NUM_OUTPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_data(sel_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef STREAM_DEMUX_STATS_EN
    , .pkt_count(pkt_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: beats ({last,data}) expected on each output, in order.
  logic [DW:0] q [N][$];
  logic        held_v [N];
  logic [DW:0] held_d [N];
  int          pkt_exp [N];
  int          drop_exp;
  int          cur_tgt;
  logic        rand_ready;
  logic        sel_fired;
  logic        in_fired;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      held_v[i]  = 1'b0;
      pkt_exp[i] = 0;
    end
    drop_exp = 0;
    cur_tgt  = -1;
  endtask

  // One clock: sample just after the negedge, score handshakes due at the next posedge, advance.
  task automatic cycle();
    logic [DW:0] obs;
    logic [DW:0] exp;
    if (rand_ready) out_ready = N'($urandom);
    #1;
    sel_fired = sel_valid && sel_ready;
    in_fired  = in_valid && in_ready;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        obs = {out_last[i], out_data[i*DW +: DW]};
        if (held_v[i]) begin
          check($sformatf("hold_out%0d", i), 64'({out_valid[i], obs}), 64'({1'b1, held_d[i]}));
        end
        held_v[i] = 1'b0;
        if (out_valid[i] === 1'b1) begin
          if (out_ready[i]) begin
            if (q[i].size() == 0) begin
              check($sformatf("unexpected_beat_out%0d", i), 64'(obs), 64'(0));
            end else begin
              exp = q[i].pop_front();
              check($sformatf("beat_out%0d", i), 64'(obs), 64'(exp));
              if (exp[DW]) pkt_exp[i]++;
            end
          end else begin
            held_v[i] = 1'b1;
            held_d[i] = obs;
          end
        end
      end
      if (sel_fired) begin
        cur_tgt = int'(sel_data);
        if (cur_tgt >= N) drop_exp++;
      end
      if (in_fired && cur_tgt >= 0 && cur_tgt < N) begin
        q[cur_tgt].push_back({in_last, in_data});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sel_valid = 1'b0;
    in_valid  = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1;
      check("rst_sel_ready", 64'(sel_ready), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    rst = 1'b0;
    clear_model();
  endtask

  task automatic send_sel(input int s);
    int n = 0;
    sel_valid = 1'b1;
    sel_data  = SW'(s);
    do begin
      cycle();
      n++;
    end while (!sel_fired && n < 200);
    check("sel_accept", 64'(sel_fired), 64'(1));
    sel_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      cycle();
      n++;
    end while (!in_fired && n < 200);
    check("beat_accept", 64'(in_fired), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef STREAM_DEMUX_STATS_EN
    check({tag, "_drop_count"}, 64'(drop_count), 64'(drop_exp));
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_pkt_count%0d", tag, i), 64'(pkt_count[i*32 +: 32]), 64'(pkt_exp[i]));
    end
`else
    check({tag, "_no_stats_pending"}, 64'(out_valid & ~out_valid), 64'(0));
`endif
  endtask

  initial begin
    rst = 1'b1; sel_valid = 1'b0; sel_data = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = '0; rand_ready = 1'b0;
    sel_fired = 1'b0; in_fired = 1'b0;
    clear_model();
    @(negedge clk);

    // Reset then idle
    do_reset(2);
    #1;
    check("idle_sel_ready", 64'(sel_ready), 64'(1));
    check("idle_in_ready", 64'(in_ready), 64'(0));
    check("idle_out_valid", 64'(out_valid), 64'(0));

    // Basic route to output 2
    out_ready = 3'b111;
    send_sel(2);
    #1;
    check("route_in_ready", 64'(in_ready), 64'(1));
    send_beat(16'h000A, 1'b0);
    #1;
    check("route_a_valid", 64'(out_valid), 64'(3'b100));
    send_beat(16'h000B, 1'b0);
    #1;
    check("route_b_valid", 64'(out_valid), 64'(3'b100));
    send_beat(16'h000C, 1'b1);
    #1;
    check("route_c_valid", 64'(out_valid), 64'(3'b100));
    check("route_c_last", 64'(out_last[2]), 64'(1));
    check("route_back_idle", 64'(sel_ready), 64'(1));
    cycle();

    // Backpressure on output 1
    out_ready = 3'b000;
    send_sel(1);
    send_beat(16'h0011, 1'b0);
    in_valid = 1'b1; in_data = 16'h0022; in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_held", 64'({out_valid, out_data[DW +: DW]}), 64'({3'b010, 16'h0011}));
      cycle();
    end
    out_ready = 3'b010;
    cycle();
    check("bp_reload_drain", 64'(in_fired), 64'(1));
    in_valid = 1'b0;
    cycle();
    cycle();
    check("bp_drained", 64'(q[1].size()), 64'(0));

    // Out-of-range select is dropped
    out_ready = 3'b111;
    send_sel(3);
    in_valid = 1'b1; in_data = 16'h0031; in_last = 1'b0;
    #1;
    check("drop_in_ready0", 64'(in_ready), 64'(1));
    cycle();
    in_data = 16'h0032; in_last = 1'b1;
    #1;
    check("drop_in_ready1", 64'(in_ready), 64'(1));
    cycle();
    in_valid = 1'b0;
    #1;
    check("drop_idle", 64'(sel_ready), 64'(1));
    check("drop_out_valid", 64'(out_valid), 64'(0));
    check_stats("drop");

    // Back-to-back packets, output 0 stalled
    out_ready = 3'b110;
    send_sel(0);
    send_beat(16'h0050, 1'b1);
    send_sel(1);
    send_beat(16'h0051, 1'b1);
    cycle();
    #1;
    check("b2b_valid", 64'(out_valid), 64'(3'b001));
    check("b2b_out0_data", 64'(out_data[0 +: DW]), 64'(16'h0050));
    check_stats("b2b_stalled");
    out_ready = 3'b111;
    cycle();
    cycle();
    check_stats("b2b_released");

    // Reset mid-packet
    send_sel(0);
    send_beat(16'h0061, 1'b0);
    do_reset(1);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_idle", 64'(sel_ready), 64'(1));
    in_valid = 1'b1; in_data = 16'h0062; in_last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("midrst_no_accept", 64'(in_fired), 64'(0));
    end
    in_valid = 1'b0;
    send_sel(0);
    send_beat(16'h0062, 1'b0);
    send_beat(16'h0063, 1'b1);
    cycle();
    cycle();

    // Randomized packets with random gaps and random output backpressure
    rand_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int s;
      int len;
      s   = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) cycle();
      send_sel(s);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 1)) cycle();
        send_beat(DW'($urandom), b == len - 1);
      end
    end
    rand_ready = 1'b0;
    out_ready  = 3'b111;
    repeat (4) cycle();
    for (int i = 0; i < N; i++) begin
      check($sformatf("final_queue%0d_empty", i), 64'(q[i].size()), 64'(0));
    end
    check_stats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
